// File: rtl/dma_read_scheduler.sv
// Round-robin scheduler sharing one burst DMA reader between NREQ job requesters.
// A granted job is issued as a single start pulse; returned beats are counted down
// to detect completion, which is signalled back to the owning requester.
module dma_read_scheduler #(
   parameter int unsigned NREQ            = 2,
   parameter int unsigned BEATS_PER_BURST = 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*32-1:0]   req_addr,
   input  logic [NREQ*16-1:0]   req_count,
   output logic [NREQ-1:0]      req_done,
   output logic [2:0]           owner,
   output logic                 busy,
   output logic                 dma_start,
   output logic [31:0]          dma_baseaddr,
   output logic [15:0]          dma_burst_count,
   input  logic                 dma_valid,
   output logic                 stray_beat
);

   // Largest job is 0xFFFF bursts; the beat counter is sized to hold it exactly.
   localparam int unsigned MaxBeats = 65535 * BEATS_PER_BURST;
   localparam int unsigned BW       = $clog2(MaxBeats + 1);

   typedef enum logic [2:0] {
      StIdle,
      StZdone,
      StIssue,
      StRun,
      StGap
   } state_e;

   state_e          state;
   logic [2:0]      rr_ptr;
   logic [BW-1:0]   beat_left;

   logic [2*NREQ-1:0] rot;
   logic              gnt_found;
   logic [2:0]        gnt_idx;
   logic [2:0]        nxt_ptr;
   logic [31:0]       sel_addr;
   logic [15:0]       sel_count;
   logic              done_now;

   // Rotate requests so rr_ptr sits at bit 0, then take the lowest set bit.
   always_comb begin
      int unsigned sum;
      sum       = 0;
      rot       = {req_valid, req_valid} >> rr_ptr;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int unsigned j = 0; j < NREQ; j++) begin
         if (!gnt_found && rot[j]) begin
            sum = 32'(rr_ptr) + j;
            if (sum >= NREQ) begin
               sum = sum - NREQ;
            end
            gnt_found = 1'b1;
            gnt_idx   = 3'(sum);
         end
      end
   end

   assign nxt_ptr = (gnt_idx == 3'(NREQ - 1)) ? 3'd0 : gnt_idx + 3'd1;

   // Select the granted requester's job descriptor.
   always_comb begin
      sel_addr  = '0;
      sel_count = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt_idx == 3'(i)) begin
            sel_addr  = req_addr[32*i +: 32];
            sel_count = req_count[16*i +: 16];
         end
      end
   end

   // Scheduler FSM with registered owner, reader command and sticky stray flag.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state           <= StIdle;
         rr_ptr          <= '0;
         owner           <= '0;
         beat_left       <= '0;
         dma_start       <= 1'b0;
         dma_baseaddr    <= '0;
         dma_burst_count <= '0;
         stray_beat      <= 1'b0;
      end else begin
         dma_start <= 1'b0;
         if (dma_valid && (state != StRun)) begin
            stray_beat <= 1'b1;
         end
         unique case (state)
            StIdle: begin
               if (gnt_found) begin
                  owner  <= gnt_idx;
                  rr_ptr <= nxt_ptr;
                  if (sel_count == 16'd0) begin
                     state <= StZdone;
                  end else begin
                     // Command is loaded here so it is already stable during the start pulse.
                     state           <= StIssue;
                     dma_start       <= 1'b1;
                     dma_baseaddr    <= sel_addr & 32'hFFFF_FFC0;
                     dma_burst_count <= sel_count;
                  end
               end
            end
            StZdone: begin
               state <= StIdle;
            end
            StIssue: begin
               beat_left <= BW'(32'(dma_burst_count) * BEATS_PER_BURST);
               state     <= StRun;
            end
            StRun: begin
               if (dma_valid) begin
                  beat_left <= beat_left - BW'(1);
                  if (beat_left == BW'(1)) begin
                     state <= StGap;
                  end
               end
            end
            StGap: begin
               // Lets the reader settle back to idle before the next start.
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

   // Accept and completion pulses; both are forced low while reset is asserted.
   always_comb begin
      req_ready = '0;
      req_done  = '0;
      done_now  = resetn &&
                  ((state == StZdone) ||
                   ((state == StRun) && dma_valid && (beat_left == BW'(1))));
      for (int unsigned i = 0; i < NREQ; i++) begin
         req_ready[i] = resetn && (state == StIdle) && gnt_found && (gnt_idx == 3'(i));
         req_done[i]  = done_now && (owner == 3'(i));
      end
   end

   assign busy = (state == StIssue) || (state == StRun) || (state == StGap);

endmodule
